// File: rtl/clk_sup_pkg.sv
// rtl/clk_sup_pkg.sv - shared states and default rates for the PLL clock supervisor
package clk_sup_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        MEASURE   = 2'd2,
        RUN       = 2'd3
    } sup_state_e;

    localparam int REF_HZ      = 50_000_000;
    localparam int CAM_XCLK_HZ = 10_000_000;
    localparam int DEF_WINDOW  = 5000;

    // Edges of the camera clock expected in one reference window.
    localparam int EXPECTED = CAM_XCLK_HZ / (REF_HZ / DEF_WINDOW);

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for asynchronous level inputs
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/pll_clock_supervisor.sv
// rtl/pll_clock_supervisor.sv - PLL reset sequencing, lock qualification and frequency check
module pll_clock_supervisor #(
    parameter int WINDOW         = clk_sup_pkg::DEF_WINDOW,
    parameter int EXPECTED       = clk_sup_pkg::EXPECTED,
    parameter int TOL            = 2,
    parameter int GOOD_WINDOWS   = 4,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 10,
    parameter int CNT_W          = 16
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             meas_clk,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             sys_rst_n,
    output logic             freq_ok,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_valid,
    output logic [7:0]       fail_count
);
    import clk_sup_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] LO_LIM    = CNT_W'(EXPECTED - TOL);
    localparam logic [CNT_W-1:0] HI_LIM    = CNT_W'(EXPECTED + TOL);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] GOOD_LAST = CNT_W'(GOOD_WINDOWS - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);

    logic meas_s2;
    logic lock_s;

    sync_2ff #(.W(1)) u_meas_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (meas_clk),
        .q     (meas_s2)
    );

    sync_2ff #(.W(1)) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    sup_state_e       state_q, state_d;
    logic [CNT_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] tally_q, tally_d;
    logic [CNT_W-1:0] meas_count_q, meas_count_d;
    logic [7:0]       fail_count_q, fail_count_d;
    logic             meas_s3_q, meas_s3_d;
    logic             win_done_q, win_done_d;
    logic             meas_valid_q, meas_valid_d;
    logic             freq_ok_q, freq_ok_d;
    logic             sys_rst_n_q, sys_rst_n_d;

    logic             rising;
    logic             windowing;
    logic             terminal;
    logic             entering;
    logic             good;
    logic [CNT_W-1:0] edge_total;

    always_comb begin
        state_d      = state_q;
        meas_s3_d    = meas_s2;
        rising       = meas_s2 & ~meas_s3_q;
        windowing    = (state_q != PLL_RST);
        terminal     = windowing && (win_cnt_q == WIN_LAST);
        edge_total   = (rising && (edge_cnt_q != '1)) ? edge_cnt_q + CNT_ONE : edge_cnt_q;
        good         = (edge_total >= LO_LIM) && (edge_total <= HI_LIM);

        // Window verdicts act one cycle after they are published; lock events win ties.
        case (state_q)
            PLL_RST: begin
                if (rst_cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s)                                  state_d = MEASURE;
                else if (win_done_q && (tally_q == TO_LAST)) state_d = PLL_RST;
            end
            MEASURE: begin
                if (!lock_s)                                 state_d = PLL_RST;
                else if (win_done_q && !freq_ok_q)           state_d = PLL_RST;
                else if (win_done_q && (tally_q == GOOD_LAST)) state_d = RUN;
            end
            default: begin
                if (!lock_s || (win_done_q && !freq_ok_q))   state_d = PLL_RST;
            end
        endcase

        entering     = (state_d != state_q);
        rst_cnt_d    = (state_q == PLL_RST && !entering) ? rst_cnt_q + CNT_ONE : '0;
        win_cnt_d    = (entering || !windowing || terminal) ? '0 : win_cnt_q + CNT_ONE;
        edge_cnt_d   = (entering || !windowing || terminal) ? '0 : edge_total;

        tally_d      = tally_q;
        if (entering)                           tally_d = '0;
        else if (win_done_q && state_q != RUN)  tally_d = tally_q + CNT_ONE;

        // A result that lands on a state change belongs to the state being left.
        win_done_d   = terminal && !entering;
        meas_valid_d = terminal;
        meas_count_d = terminal ? edge_total : meas_count_q;
        freq_ok_d    = terminal ? good : freq_ok_q;
        sys_rst_n_d  = (state_d == RUN);

        fail_count_d = fail_count_q;
        if (entering && (state_d == PLL_RST) && (fail_count_q != 8'hFF))
            fail_count_d = fail_count_q + 8'd1;
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= PLL_RST;
            rst_cnt_q    <= '0;
            win_cnt_q    <= '0;
            edge_cnt_q   <= '0;
            tally_q      <= '0;
            meas_count_q <= '0;
            fail_count_q <= '0;
            meas_s3_q    <= 1'b0;
            win_done_q   <= 1'b0;
            meas_valid_q <= 1'b0;
            freq_ok_q    <= 1'b0;
            sys_rst_n_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            win_cnt_q    <= win_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            tally_q      <= tally_d;
            meas_count_q <= meas_count_d;
            fail_count_q <= fail_count_d;
            meas_s3_q    <= meas_s3_d;
            win_done_q   <= win_done_d;
            meas_valid_q <= meas_valid_d;
            freq_ok_q    <= freq_ok_d;
            sys_rst_n_q  <= sys_rst_n_d;
        end
    end

    assign pll_rst    = (state_q == PLL_RST);
    assign sys_rst_n  = sys_rst_n_q;
    assign freq_ok    = freq_ok_q;
    assign meas_count = meas_count_q;
    assign meas_valid = meas_valid_q;
    assign fail_count = fail_count_q;

endmodule

// File: tb/tb_pll_clock_supervisor.sv
// tb/tb_pll_clock_supervisor.sv - randomized self-checking bench for pll_clock_supervisor
module tb_pll_clock_supervisor;

    localparam int W        = 64;
    localparam int E        = 16;
    localparam int TOL      = 2;
    localparam int GW       = 4;
    localparam int PRC      = 16;
    localparam int LT       = 2;
    localparam int CW       = 16;
    localparam int LOCK_DLY = 12;

    logic          refclk     = 1'b0;
    logic          rst_n      = 1'b0;
    logic          meas_clk   = 1'b0;
    logic          pll_locked = 1'b0;
    logic          pll_rst;
    logic          sys_rst_n;
    logic          freq_ok;
    logic [CW-1:0] meas_count;
    logic          meas_valid;
    logic [7:0]    fail_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_fail = 0;
    int rate_n   = E;
    int acc      = 0;
    int lk_cnt   = 0;
    bit lock_en  = 1'b1;

    always #5 refclk = ~refclk;

    pll_clock_supervisor #(
        .WINDOW         (W),
        .EXPECTED       (E),
        .TOL            (TOL),
        .GOOD_WINDOWS   (GW),
        .PLL_RST_CYCLES (PRC),
        .LOCK_TIMEOUT   (LT),
        .CNT_W          (CW)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .meas_clk   (meas_clk),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .freq_ok    (freq_ok),
        .meas_count (meas_count),
        .meas_valid (meas_valid),
        .fail_count (fail_count)
    );

    // Pulse stream with exactly rate_n pulses in any W consecutive cycles; PLL locks
    // LOCK_DLY cycles after its reset is released while lock_en is set.
    always @(posedge refclk) begin
        #2;
        acc = acc + rate_n;
        if (acc >= W) begin
            acc      = acc - W;
            meas_clk = 1'b1;
        end else begin
            meas_clk = 1'b0;
        end
        if (pll_rst || !lock_en) lk_cnt = 0;
        else if (lk_cnt < LOCK_DLY) lk_cnt = lk_cnt + 1;
        pll_locked = (lk_cnt >= LOCK_DLY);
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return pll_rst;
            1:       return meas_valid;
            2:       return sys_rst_n;
            default: return pll_locked;
        endcase
    endfunction

    task automatic wait_cond(input int which, input logic val, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (sig(which) === val) return;
            @(negedge refclk);
        end
        check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic run_len(input int which, input logic val, input int budget, output int n);
        n = 1;
        while (n < budget) begin
            @(negedge refclk);
            if (sig(which) !== val) return;
            n++;
        end
    endtask

    task automatic note_fail();
        if (exp_fail < 255) exp_fail++;
    endtask

    task automatic trial(input int n);
        bit good;
        int len;
        good   = (n >= E - TOL) && (n <= E + TOL);
        rate_n = n;
        wait_cond(3, 1'b1, 400, "lock");
        if (good) begin
            for (int k = 1; k <= GW; k++) begin
                @(negedge refclk);
                wait_cond(1, 1'b1, W + 8, "mv_good");
                check("meas_count", meas_count, n);
                check("freq_ok", freq_ok, 1);
                check("sys_rst_n_pre", sys_rst_n, 0);
            end
            @(negedge refclk);
            check("sys_rst_n_run", sys_rst_n, 1);
            @(negedge refclk);
            wait_cond(1, 1'b1, W + 8, "mv_run");
            check("run_meas_count", meas_count, n);
            check("run_freq_ok", freq_ok, 1);
            check("run_fail_count", fail_count, exp_fail);
            lock_en = 1'b0;
            wait_cond(3, 1'b0, 4, "lock_drop");
            len = 0;
            while (sys_rst_n && len < 8) begin
                @(negedge refclk);
                len++;
            end
            check("drop_sys_rst_within_4", (len <= 4), 1);
            wait_cond(0, 1'b1, 4, "drop_pll_rst");
            lock_en = 1'b1;
        end else begin
            @(negedge refclk);
            wait_cond(1, 1'b1, W + 8, "mv_bad");
            check("bad_meas_count", meas_count, n);
            check("bad_freq_ok", freq_ok, 0);
            check("bad_sys_rst_n", sys_rst_n, 0);
            wait_cond(0, 1'b1, 4, "bad_pll_rst");
        end
        run_len(0, 1'b1, 64, len);
        check("pll_rst_len", len, PRC);
        check("retry_sys_rst_n", sys_rst_n, 0);
        note_fail();
        check("fail_count", fail_count, exp_fail);
    endtask

    initial begin
        int len;
        repeat (3) @(negedge refclk);
        check("rst_pll_rst", pll_rst, 1);
        check("rst_sys_rst_n", sys_rst_n, 0);
        check("rst_freq_ok", freq_ok, 0);
        check("rst_meas_count", meas_count, 0);
        check("rst_meas_valid", meas_valid, 0);
        check("rst_fail_count", fail_count, 0);
        rst_n = 1'b1;

        trial(E);
        trial(E + 2);
        trial(E - 2);
        trial(E + 5);
        trial(E + 3);
        trial(0);
        for (int i = 0; i < 6; i++) trial(int'($urandom_range(E + 5, E - 5)));

        rate_n = E;
        wait_cond(3, 1'b1, 400, "lock_mid");
        for (int k = 0; k < GW; k++) begin
            @(negedge refclk);
            wait_cond(1, 1'b1, W + 8, "mv_mid");
        end
        repeat (W / 2) @(negedge refclk);
        check("mid_in_run", sys_rst_n, 1);
        #3 rst_n = 1'b0;
        #1;
        check("async_pll_rst", pll_rst, 1);
        check("async_sys_rst_n", sys_rst_n, 0);
        check("async_freq_ok", freq_ok, 0);
        check("async_meas_count", meas_count, 0);
        check("async_meas_valid", meas_valid, 0);
        check("async_fail_count", fail_count, 0);
        exp_fail = 0;
        lock_en  = 1'b0;
        @(negedge refclk);
        rst_n = 1'b1;

        for (int r = 1; r <= 258; r++) begin
            wait_cond(0, 1'b0, 64, "to_rst_fall");
            run_len(0, 1'b0, LT * W + 16, len);
            if (r <= 3) check("timeout_len_in_range", (len >= LT * W && len <= LT * W + 2), 1);
            note_fail();
            check("timeout_fail_count", fail_count, exp_fail);
            if (r == 1) begin
                run_len(0, 1'b1, 64, len);
                check("timeout_pll_rst_len", len, PRC);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_clock_supervisor.md
Name: pll_clock_supervisor

Overview:
- Consumes the camera-clock PLL outputs (`outclk_0` and `locked`) and drives the PLL's active-high reset.
- Measures the generated clock against the 50 MHz reference and qualifies lock.
- Holds the downstream system reset until the frequency checks good. On lock loss, lock timeout, or out-of-tolerance frequency, it re-resets the PLL.
- Sits between the 10 MHz camera PLL and the OV7670 capture/SCCB logic.

Parameters:
- WINDOW, 5000: refclk cycles per measurement window (100 us at 50 MHz).
- EXPECTED, 1000: expected meas_clk rising edges per window (10 MHz).
- TOL, 2: allowed absolute edge-count deviation.
- GOOD_WINDOWS, 4: consecutive good windows required before releasing sys_rst_n.
- PLL_RST_CYCLES, 16: refclk cycles pll_rst is held high per reset attempt.
- LOCK_TIMEOUT, 10: windows to wait for locked before retrying.
- CNT_W, 16: width of edge and window counters.

Ports:
- refclk  in  1  50 MHz reference; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- meas_clk  in  1  PLL output under test; asynchronous, sampled as data.
- pll_locked  in  1  PLL locked; asynchronous.
- pll_rst  out  1  active-high reset to the PLL.
- sys_rst_n  out  1  active-low reset to downstream camera logic.
- freq_ok  out  1  last completed window was within tolerance.
- meas_count  out  CNT_W  edge count of last completed window.
- meas_valid  out  1  one-cycle pulse when meas_count updates.
- fail_count  out  8  number of PLL reset retries, saturating at 255.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State = PLL_RST; pll_rst=1, sys_rst_n=0.
  - freq_ok=0, meas_count=0, meas_valid=0, fail_count=0; all counters 0.
- Synchronisers:
  - meas_clk and pll_locked each pass through 2-flop synchronisers.
  - A third flop on meas_clk gives rising-edge detect (edge = s2 & ~s3).
  - Lock/edge latency is 3 refclk cycles.
- Edge counter:
  - Increments on each detected edge; saturates at all-ones.
  - An edge on a window's terminal cycle counts into the ending window.
  - The counter then restarts at 0 for the next window.
- Window counter:
  - Counts 0..WINDOW-1 and wraps.
  - Runs in WAIT_LOCK, MEASURE and RUN; cleared on every state entry.
- At window terminal count:
  - meas_count <= edge count; meas_valid=1 for one cycle.
  - good = (edge count >= EXPECTED-TOL) && (edge count <= EXPECTED+TOL).
  - freq_ok <= good.
- FSM:
  - PLL_RST: pll_rst=1 for PLL_RST_CYCLES cycles, then go to WAIT_LOCK.
  - WAIT_LOCK: pll_rst=0. On synchronised lock, go to MEASURE. After LOCK_TIMEOUT completed windows without lock, go to PLL_RST.
  - MEASURE: track a good-window streak counter.
    - Good window: streak++. When streak reaches GOOD_WINDOWS, go to RUN.
    - Bad window: streak=0 and go to PLL_RST.
    - Lock lost: go to PLL_RST immediately.
  - RUN: sys_rst_n=1. Measurement continues. A bad window or lock loss sends the FSM to PLL_RST.
- sys_rst_n:
  - Registered; 1 only in RUN.
  - Driven to 0 on the same edge the FSM leaves RUN.
- fail_count: increments on every transition into PLL_RST other than from reset; saturates at 255.
- Simultaneous events in the same cycle: lock loss takes priority over a window result; timeout and lock arrival resolve to MEASURE.
- rst_n asserted mid-window: all state is discarded and the partial count is lost.

Decomposition:
- Shared package `clk_sup_pkg`:
  - State enum {PLL_RST, WAIT_LOCK, MEASURE, RUN}.
  - Default constants REF_HZ=50_000_000 and CAM_XCLK_HZ=10_000_000.
  - Helper constant EXPECTED = CAM_XCLK_HZ/(REF_HZ/WINDOW).
- Sub-module `sync_2ff`: parameterised width, asynchronous active-low reset; instantiated for meas_clk and pll_locked.

Test Plan:
- 10.000 MHz meas_clk, locked high 2 us after pll_rst falls:
  - meas_count=1000 each window; freq_ok=1.
  - sys_rst_n rises one cycle after the 4th meas_valid in MEASURE.
  - fail_count=0.
- 10.05 MHz meas_clk (1005 edges/window):
  - freq_ok=0 on the first window; FSM returns to PLL_RST.
  - pll_rst high for 16 cycles; fail_count=1; sys_rst_n stays 0.
- 10.02 MHz (1002 edges) and 9.98 MHz (998 edges): both within tolerance; RUN reached; freq_ok=1.
- pll_locked never asserts: after 10 windows (50000 cycles) pll_rst pulses for 16 cycles; fail_count increments once per timeout and saturates at 255.
- In RUN, pll_locked drops:
  - sys_rst_n=0 within 4 cycles of the drop.
  - pll_rst=1 for 16 cycles.
  - Re-lock followed by 4 good windows returns to RUN.
- meas_clk stuck low in MEASURE: meas_count=0, freq_ok=0, retry. Separately, rst_n pulsed mid-window: all outputs return to reset values asynchronously.
